// File: rtl/tx_fifo_pkg.sv
// Shared sizing, data and pointer types for the transmit-side byte FIFO.
// Optional error-flag feature is controlled by the TX_FIFO_ERR_EN macro.
package tx_fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int ADDR_W     = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] fifo_data_t;
    typedef logic [ADDR_W:0]       fifo_ptr_t;

    localparam fifo_ptr_t PTR_ZERO = {(ADDR_W+1){1'b0}};
    localparam fifo_ptr_t PTR_ONE  = fifo_ptr_t'(1'b1);

endpackage

// File: rtl/tx_fifo_ctrl.sv
// Pointer, full/empty and error-flag control for tx_fifo.
// With TX_FIFO_ERR_EN defined, sticky overflow/underflow outputs are added.
module tx_fifo_ctrl
    import tx_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              write_enable,
    input  logic              read_enable,
    output logic              do_write,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic              fifo_empty,
    output logic              fifo_full
`ifdef TX_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    fifo_ptr_t wptr_r;
    fifo_ptr_t rptr_r;
    logic      do_read_s;

    // Flags and accepted operations, all derived from registered pointers.
    // A write while full is accepted only when a pop frees the slot on the same edge.
    always_comb begin
        fifo_empty = (wptr_r == rptr_r);
        fifo_full  = (wptr_r[ADDR_W-1:0] == rptr_r[ADDR_W-1:0]) &&
                     (wptr_r[ADDR_W] != rptr_r[ADDR_W]);
        do_read_s  = read_enable && !fifo_empty;
        do_write   = write_enable && (!fifo_full || do_read_s);
        waddr      = wptr_r[ADDR_W-1:0];
        raddr      = rptr_r[ADDR_W-1:0];
    end

    // Write and read pointers, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_r <= PTR_ZERO;
            rptr_r <= PTR_ZERO;
        end else begin
            if (do_write) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (do_read_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

`ifdef TX_FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (write_enable && !do_write) begin
                overflow_r <= 1'b1;
            end
            if (read_enable && fifo_empty) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`endif

endmodule

// File: rtl/tx_fifo.sv
// Transmit-side 8x8 first-word-fall-through FIFO: storage array and head mux.
// Define TX_FIFO_ERR_EN to expose sticky overflow/underflow outputs.
module tx_fifo
    import tx_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  fifo_empty,
    output logic                  fifo_full
`ifdef TX_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    fifo_data_t        mem_r [DEPTH];
    logic              do_write_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [ADDR_W-1:0] raddr_s;

    tx_fifo_ctrl u_ctrl (
        .clk          (clk),
        .n_rst        (n_rst),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .do_write     (do_write_s),
        .waddr        (waddr_s),
        .raddr        (raddr_s),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full)
`ifdef TX_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // Storage array; intentionally not reset, emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem_r[waddr_s] <= write_data;
        end
    end

    // Head-of-queue presentation, forced to zero when empty.
    always_comb begin
        if (fifo_empty) begin
            read_data = {DATA_WIDTH{1'b0}};
        end else begin
            read_data = mem_r[raddr_s];
        end
    end

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo: queue-based reference plus directed literal checks.
// Compile with +define+TX_FIFO_ERR_EN to also check the sticky error flags.
module tb_tx_fifo;

    logic       clk;
    logic       n_rst;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic [7:0] read_data;
    logic       fifo_empty;
    logic       fifo_full;
`ifdef TX_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    tx_fifo dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full)
`ifdef TX_FIFO_ERR_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total_checks = 0;
    int         passed_checks = 0;
    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    logic       model_unf = 1'b0;
    logic       cmp_on = 1'b0;
    logic [7:0] exp_data;
    logic [7:0] exp_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour at one clock edge: an 8-deep ordered queue.
    task automatic model_edge(input logic we, input logic [7:0] wd, input logic re);
        int  n;
        logic popped;
        n = model_q.size();
        popped = 1'b0;
        if (re && n == 0) model_unf = 1'b1;
        if (re && n > 0) begin
            void'(model_q.pop_front());
            popped = 1'b1;
        end
        if (we) begin
            if (n < 8 || popped) model_q.push_back(wd);
            else model_ovf = 1'b1;
        end
    endtask

    task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        @(posedge clk);
        model_edge(we, wd, re);
        @(negedge clk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    // Per-cycle comparison of all outputs against the reference queue.
    always @(negedge clk) begin
        if (cmp_on) begin
            exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
            chk("cmp_read_data", {24'd0, read_data}, {24'd0, exp_data});
            chk("cmp_empty", {31'd0, fifo_empty}, {31'd0, model_q.size() == 0});
            chk("cmp_full", {31'd0, fifo_full}, {31'd0, model_q.size() == 8});
`ifdef TX_FIFO_ERR_EN
            chk("cmp_overflow", {31'd0, overflow}, {31'd0, model_ovf});
            chk("cmp_underflow", {31'd0, underflow}, {31'd0, model_unf});
`endif
        end
    end

    initial begin
        n_rst = 1'b0;
        write_enable = 1'b0;
        write_data = 8'h00;
        read_enable = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_empty", {31'd0, fifo_empty}, 32'd1);
        chk("reset_full", {31'd0, fifo_full}, 32'd0);
        chk("reset_data", {24'd0, read_data}, 32'd0);
        n_rst = 1'b1;

        // 1: single write becomes visible on the head
        cyc(1'b1, 8'hFF, 1'b0);
        idle(2);
        chk("t1_data", {24'd0, read_data}, 32'h0000_00FF);
        chk("t1_empty", {31'd0, fifo_empty}, 32'd0);
        chk("t1_full", {31'd0, fifo_full}, 32'd0);

        // 2: two reads, the second on an empty FIFO
        cyc(1'b0, 8'h00, 1'b1);
        idle(1);
        cyc(1'b0, 8'h00, 1'b1);
        idle(4);
        chk("t2_empty", {31'd0, fifo_empty}, 32'd1);
        chk("t2_data", {24'd0, read_data}, 32'd0);
`ifdef TX_FIFO_ERR_EN
        chk("t2_underflow", {31'd0, underflow}, 32'd1);
`endif

        // 3: fill with 0xC7, then one ignored write
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'hC7, 1'b0);
            idle(1);
        end
        chk("t3_full", {31'd0, fifo_full}, 32'd1);
        cyc(1'b1, 8'h55, 1'b0);
        chk("t3_head", {24'd0, read_data}, 32'h0000_00C7);
        chk("t3_full_after", {31'd0, fifo_full}, 32'd1);
`ifdef TX_FIFO_ERR_EN
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
`endif

        // 4: drain, every head is 0xC7
        for (int i = 0; i < 8; i++) begin
            chk("t4_head", {24'd0, read_data}, 32'h0000_00C7);
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("t4_full", {31'd0, fifo_full}, 32'd0);
        chk("t4_empty", {31'd0, fifo_empty}, 32'd1);

        // 5: 0x01..0x0C across the pointer wrap, with read+write while full
        for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("t5_full", {31'd0, fifo_full}, 32'd1);
        exp_next = 8'h01;
        for (int i = 9; i <= 12; i++) begin
            chk("t5_order", {24'd0, read_data}, {24'd0, exp_next});
            exp_next = exp_next + 8'h01;
            cyc(1'b1, 8'(i), 1'b1);
            chk("t5_full_rw", {31'd0, fifo_full}, 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t5_order", {24'd0, read_data}, {24'd0, exp_next});
            exp_next = exp_next + 8'h01;
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("t5_empty", {31'd0, fifo_empty}, 32'd1);

        // 6: asynchronous reset with 5 entries held
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h21 + i), 1'b0);
        chk("t6_pre_data", {24'd0, read_data}, 32'h0000_0021);
        #2;
        n_rst = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        #1;
        chk("t6_empty", {31'd0, fifo_empty}, 32'd1);
        chk("t6_full", {31'd0, fifo_full}, 32'd0);
        chk("t6_data", {24'd0, read_data}, 32'd0);
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0);
        chk("t6_post_data", {24'd0, read_data}, 32'h0000_003C);
        idle(2);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
